mips_avalon_bridge: RTL and testbench

- Single-outstanding Avalon-MM register-slice bridge between the CPU bus master (mips_cpu_bus) and the memory slave.
- Latches each master request, re-issues it to the slave from registers, and returns read data with one registered response cycle.
- Checks protocol: simultaneous read/write, misalignment, zero byteenable, slave timeout.
- Exposes a sticky error code and a completed-transaction counter to the bench.

---
 rtl/mips_avalon_pkg.sv | 18 +
 rtl/mips_avalon_bridge.sv | 113 +++++++++++
 tb/tb_mips_avalon_bridge.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the CPU-bus to memory Avalon-MM bridge.
package mips_avalon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } bridge_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RDWR    = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [31:0] DEFAULT_ERR_READDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mips_avalon_bridge.sv
// Single-outstanding Avalon-MM register slice with protocol checks, a slave
// timeout, a sticky first-error code and a completed-transaction counter.
module mips_avalon_bridge
  import mips_avalon_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_READDATA   = DEFAULT_ERR_READDATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_address,
  input  logic [3:0]  s_byteenable,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic [31:0] m_address,
  output logic [3:0]  m_byteenable,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] txn_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TCNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  bridge_state_t state;
  logic [CW-1:0] tcnt;
  logic          go_err;
  logic [1:0]    go_err_code;

  assign s_waitrequest = !(state == DONE || state == ERR);

  // Both error sources (bad request in IDLE, slave timeout in ISSUE) funnel
  // into one ERR entry path so the sticky-code rule lives in one place.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    go_err      = 1'b0;
    go_err_code = ERR_NONE;
    if (state == IDLE && (s_read || s_write)) begin
      if (s_read && s_write) begin
        go_err      = 1'b1;
        go_err_code = ERR_RDWR;
      end else if (s_address[1:0] != 2'b00 || s_byteenable == 4'b0000) begin
        go_err      = 1'b1;
        go_err_code = ERR_ALIGN;
      end
    end else if (state == ISSUE && m_waitrequest && tcnt == TCNT_LAST) begin
      go_err      = 1'b1;
      go_err_code = ERR_TIMEOUT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      tcnt         <= '0;
      m_address    <= '0;
      m_byteenable <= '0;
      m_writedata  <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      s_readdata   <= '0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      txn_count    <= '0;
    end else if (go_err) begin
      state      <= ERR;
      m_read     <= 1'b0;
      m_write    <= 1'b0;
      s_readdata <= ERR_READDATA;
      err        <= 1'b1;
      if (err_code == ERR_NONE) err_code <= go_err_code;
    end else begin
      case (state)
        IDLE: begin
          if (s_read || s_write) begin
            m_address    <= s_address;
            m_byteenable <= s_byteenable;
            m_writedata  <= s_writedata;
            m_read       <= s_read;
            m_write      <= s_write;
            tcnt         <= '0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (!m_waitrequest) begin
            s_readdata <= m_read ? m_readdata : 32'h0;
            m_read     <= 1'b0;
            m_write    <= 1'b0;
            state      <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          txn_count <= txn_count + 32'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_avalon_bridge.sv
// Bench for mips_avalon_bridge: directed and randomized transactions checked
// against a transaction-level model of latency, slave accesses and error rules.
module tb_mips_avalon_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_address;
  logic [3:0]  s_byteenable;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic [31:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] txn_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state: sticky error, first error code, good-transaction count.
  logic        err_m;
  logic [1:0]  code_m;
  logic [31:0] txn_m;

  mips_avalon_bridge #(.TIMEOUT_CYCLES(TO), .ERR_READDATA(32'hDEADBEEF)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_address    (s_address),
    .s_byteenable (s_byteenable),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_writedata  (s_writedata),
    .s_waitrequest(s_waitrequest),
    .s_readdata   (s_readdata),
    .m_address    (m_address),
    .m_byteenable (m_byteenable),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_writedata  (m_writedata),
    .m_waitrequest(m_waitrequest),
    .m_readdata   (m_readdata),
    .err          (err),
    .err_code     (err_code),
    .txn_count    (txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    s_address     = '0;
    s_byteenable  = '0;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_writedata   = '0;
    m_waitrequest = 1'b1;
    m_readdata    = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst:s_waitrequest", s_waitrequest, 1);
    check("rst:m_rw", {m_read, m_write}, 0);
    check("rst:m_data", {m_address, m_byteenable, m_writedata}, 0);
    check("rst:s_readdata", s_readdata, 0);
    check("rst:err", {err, err_code}, 0);
    check("rst:txn_count", txn_count, 0);
    reset  = 1'b1;
    err_m  = 1'b0;
    code_m = 2'b00;
    txn_m  = '0;
    @(negedge clk);
  endtask

  // One master transaction with a slave that stalls `waits` cycles per access.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic [3:0] be,
                         input logic rd, input logic wr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits);
    logic [1:0]  code;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    int          exp_lat, exp_acc, cyc, acc;
    bit          done;
    logic [31:0] junk;

    if (rd && wr)                          code = 2'b01;
    else if (addr[1:0] != 0 || be == 0)    code = 2'b10;
    else if (waits >= TO)                  code = 2'b11;
    else                                   code = 2'b00;

    // Latency counted in posedges from the one that samples the request
    // to the one where the master sees s_waitrequest low.
    case (code)
      2'b00:   begin exp_lat = waits + 2; exp_acc = waits + 1; end
      2'b11:   begin exp_lat = TO + 1;    exp_acc = TO;        end
      default: begin exp_lat = 1;         exp_acc = 0;         end
    endcase
    exp_rd = (code != 2'b00) ? 32'hDEADBEEF : (rd ? rdata : 32'h0);

    s_address     = addr;
    s_byteenable  = be;
    s_read        = rd;
    s_write       = wr;
    s_writedata   = wdata;
    m_waitrequest = 1'b1;
    m_readdata    = rdata;
    cyc = 0; acc = 0; done = 0; got_rd = '0;

    while (!done && cyc < 4 * TO + 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (m_read || m_write) begin
        acc++;
        check({tag, ":m_cmd"}, {m_read, m_write, m_byteenable, m_address}, {rd, wr, be, addr});
        check({tag, ":m_writedata"}, m_writedata, wdata);
        junk         = $urandom();
        s_address    = junk;
        s_writedata  = ~junk;
        s_byteenable = junk[3:0];
        m_waitrequest = (acc <= waits);
      end else begin
        m_waitrequest = 1'b1;
      end
      if (!s_waitrequest) begin
        done   = 1;
        got_rd = s_readdata;
      end
    end

    if (code != 2'b00) begin
      err_m = 1'b1;
      if (code_m == 2'b00) code_m = code;
    end else begin
      txn_m = txn_m + 32'd1;
    end

    check({tag, ":completed"}, done, 1);
    check({tag, ":latency"}, cyc, exp_lat);
    check({tag, ":accesses"}, acc, exp_acc);
    check({tag, ":s_readdata"}, got_rd, exp_rd);
    check({tag, ":err"}, {err, err_code}, {err_m, code_m});

    @(negedge clk);
    idle_inputs();
    check({tag, ":one_cycle_ack"}, s_waitrequest, 1);
    check({tag, ":m_idle"}, {m_read, m_write}, 0);
    check({tag, ":txn_count"}, txn_count, txn_m);
  endtask

  initial begin
    logic [31:0] a, d, r;
    logic [3:0]  be;
    int          sel;

    idle_inputs();
    reset = 1'b1;
    apply_reset();

    run_txn("rd_wait2", 32'hBFC00000, 4'hF, 1, 0, 32'h0, 32'h12345678, 2);
    run_txn("wr_zero", 32'h00001004, 4'h3, 0, 1, 32'hAABBCCDD, 32'h0, 0);
    run_txn("rd_misaligned", 32'h00001002, 4'hF, 1, 0, 32'h0, 32'h0, 0);
    run_txn("rd_after_err", 32'h00002000, 4'hF, 1, 0, 32'h0, 32'hCAFEF00D, 1);
    run_txn("wr_wait7", 32'h00003000, 4'hC, 0, 1, 32'h01020304, 32'h0, TO - 1);

    // Reset in the middle of ISSUE: slave strobes must drop without a clock edge.
    s_address = 32'h00004000; s_byteenable = 4'hF; s_read = 1'b1;
    m_waitrequest = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst:issuing", m_read, 1);
    reset = 1'b0;
    #1;
    check("mid_rst:m_read_async", {m_read, m_write}, 0);
    check("mid_rst:s_waitrequest", s_waitrequest, 1);
    idle_inputs();
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    err_m  = 1'b0;
    code_m = 2'b00;
    txn_m  = '0;
    @(negedge clk);
    check("mid_rst:state_clean", {err, err_code, m_read, m_write, s_waitrequest}, 6'b000001);
    check("mid_rst:txn_count", txn_count, 0);

    run_txn("rdwr", 32'h00005000, 4'hF, 1, 1, 32'h11112222, 32'h0, 0);
    run_txn("rd_after_rdwr", 32'h00005004, 4'h1, 1, 0, 32'h0, 32'h000000A5, 0);

    apply_reset();
    run_txn("timeout", 32'h00006000, 4'hF, 1, 0, 32'h0, 32'h55555555, 1000);
    run_txn("be_zero", 32'h00006004, 4'h0, 0, 1, 32'h77777777, 32'h0, 0);

    apply_reset();
    for (int i = 0; i < 60; i++) begin
      if (i == 30) apply_reset();
      sel = $urandom_range(0, 19);
      a   = $urandom();
      d   = $urandom();
      r   = $urandom();
      be  = 4'($urandom_range(1, 15));
      a[1:0] = 2'b00;
      case (sel)
        0:       run_txn("rnd_rdwr", a, be, 1, 1, d, r, 0);
        1:       begin a[1:0] = 2'($urandom_range(1, 3)); run_txn("rnd_align", a, be, 1, 0, d, r, 0); end
        2:       run_txn("rnd_be0", a, 4'h0, 0, 1, d, r, 0);
        default: run_txn(sel[0] ? "rnd_rd" : "rnd_wr", a, be, sel[0], !sel[0], d, r,
                         $urandom_range(0, 9));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
